// File: rtl/mul_issue.sv
// mul_issue -- requester-side controller for the shared Booth radix-4
// multiplier in the EXU.
//
// Accepts one RV64M multiply uop at a time (MUL, MULH, MULHSU, MULHU, MULW),
// forms the 65-bit signed operands, requests the multiplier with a
// valid/ready handshake, captures the single-cycle product pulse, selects
// the low half, the high half or a sign-extended word, and holds the result
// toward writeback until it is taken. A flush kills the in-flight op; if
// the multiplier has already accepted it, the controller waits in DRAIN
// for the product pulse and discards it.
//
// Optional feature (compile-time macro MUL_ZERO_BYPASS_EN):
//   when defined, an op whose formed operand is zero skips the multiplier
//   and presents a zero result in the cycle after accept.
//
// Parameters:
//   TAG_W            destination tag width
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   flush            kill any in-flight op
//   in_valid/in_ready, in_op, in_src1, in_src2, in_tag
//                    issue-side handshake and op fields
//   out_valid/out_ready, out_result, out_tag
//                    writeback-side handshake and result
//   mul_valid/mul_ready, mul_multiplicand, mul_multiplier
//                    multiplier request handshake and 65-bit operands
//   mul_out_valid, mul_product
//                    multiplier one-cycle result pulse and 128-bit product

module mul_issue #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [63:0]      in_src1,
    input  logic [63:0]      in_src2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             mul_valid,
    input  logic             mul_ready,
    output logic [64:0]      mul_multiplicand,
    output logic [64:0]      mul_multiplier,
    input  logic             mul_out_valid,
    input  logic [127:0]     mul_product
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_t;
    typedef enum logic [1:0] {SEL_LO, SEL_HI, SEL_W} sel_t;

    state_t      state_q, state_d;
    sel_t        sel_q, sel_d;
    logic [64:0] opa_d, opb_d;
    logic [63:0] result_sel;
    logic        accept;
    logic        bypass;

    // Operand forming and result-select decode for the op being presented.
    // Undefined op encodings fall through to the MUL defaults.
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        sel_d = SEL_LO;
        opa_d = {in_src1[63], in_src1};
        opb_d = {in_src2[63], in_src2};
        case (in_op)
            3'b001: sel_d = SEL_HI;
            3'b010: begin
                sel_d = SEL_HI;
                opb_d = {1'b0, in_src2};
            end
            3'b011: begin
                sel_d = SEL_HI;
                opa_d = {1'b0, in_src1};
                opb_d = {1'b0, in_src2};
            end
            3'b100: begin
                sel_d = SEL_W;
                opa_d = {{33{in_src1[31]}}, in_src1[31:0]};
                opb_d = {{33{in_src2[31]}}, in_src2[31:0]};
            end
            default: ;
        endcase
    end

    assign in_ready = (state_q == S_IDLE);
    assign accept   = in_ready && in_valid && !flush;

`ifdef MUL_ZERO_BYPASS_EN
    // A zero operand makes every selection zero, so the multiplier is skipped.
    assign bypass = (opa_d == '0) || (opb_d == '0);
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        case (sel_q)
            SEL_HI:  result_sel = mul_product[127:64];
            SEL_W:   result_sel = {{32{mul_product[31]}}, mul_product[31:0]};
            default: result_sel = mul_product[63:0];
        endcase
    end

    // Next-state logic. Once the multiplier has taken a request it cannot be
    // aborted, so a flush after that point must wait out the product in DRAIN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = bypass ? S_DONE : S_REQ;
            S_REQ: begin
                if (flush)          state_d = mul_ready ? S_DRAIN : S_IDLE;
                else if (mul_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mul_out_valid)  state_d = flush ? S_IDLE : S_DONE;
                else if (flush)     state_d = S_DRAIN;
            end
            S_DONE:  if (flush || out_ready) state_d = S_IDLE;
            S_DRAIN: if (mul_out_valid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register; the handshake outputs are registered from the next
    // state so they line up exactly with the state they describe.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mul_valid <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            mul_valid <= (state_d == S_REQ);
            out_valid <= (state_d == S_DONE);
        end
    end

    // Datapath registers. Operands are loaded only at accept, so they stay
    // stable for the whole REQ phase; the result loads only on a live product.
    // NOTE: these data registers are reset as well because their reset value
    // is visible on the ports.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q            <= SEL_LO;
            out_tag          <= '0;
            out_result       <= '0;
            mul_multiplicand <= '0;
            mul_multiplier   <= '0;
        end else begin
            if (accept) begin
                sel_q            <= sel_d;
                out_tag          <= in_tag;
                mul_multiplicand <= opa_d;
                mul_multiplier   <= opb_d;
                if (bypass) out_result <= '0;
            end
            if ((state_q == S_WAIT) && mul_out_valid && !flush) begin
                out_result <= result_sel;
            end
        end
    end

endmodule

// File: tb/tb_mul_issue.sv
// tb_mul_issue -- self-checking bench for mul_issue.
// The bench plays both the issue stage and the multiplier. Expected results
// come from a reference model that evaluates each RV64M op directly on the
// 64-bit sources with wide unsigned arithmetic.

`timescale 1ns/1ps

module tb_mul_issue;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [63:0]      in_src1;
    logic [63:0]      in_src2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             mul_valid;
    logic             mul_ready;
    logic [64:0]      mul_multiplicand;
    logic [64:0]      mul_multiplier;
    logic             mul_out_valid;
    logic [127:0]     mul_product;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_issue #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag),
        .mul_valid(mul_valid), .mul_ready(mul_ready),
        .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
        .mul_out_valid(mul_out_valid), .mul_product(mul_product)
    );

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        logic [31:0]  w;
        case (op)
            3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
            3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b};       return p[127:64]; end
            3'd3: begin p = {64'd0, a} * {64'd0, b};             return p[127:64]; end
            3'd4: begin w = a[31:0] * b[31:0]; return {{32{w[31]}}, w}; end
            default: return a * b;
        endcase
    endfunction

    function automatic logic [64:0] ref_opa(input logic [2:0] op, input logic [63:0] a);
        case (op)
            3'd3:    return {1'b0, a};
            3'd4:    return {{33{a[31]}}, a[31:0]};
            default: return {a[63], a};
        endcase
    endfunction

    function automatic logic [64:0] ref_opb(input logic [2:0] op, input logic [63:0] b);
        case (op)
            3'd2, 3'd3: return {1'b0, b};
            3'd4:       return {{33{b[31]}}, b[31:0]};
            default:    return {b[63], b};
        endcase
    endfunction

    // The multiplier's job: full signed product of the 65-bit operands.
    function automatic logic [127:0] mul65(input logic [64:0] x, input logic [64:0] y);
        logic [129:0] p;
        p = {{65{x[64]}}, x} * {{65{y[64]}}, y};
        return p[127:0];
    endfunction

    function automatic logic [63:0] rand_operand();
        case ($urandom_range(0, 6))
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'($urandom_range(1, 15));
            4:       return {$urandom, 32'd0};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // ---------------- stimulus helpers (all start and end at a negedge) ----------------
    task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input logic [TAG_W-1:0] tag);
        in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; in_tag = tag;
        @(negedge clk);
        in_valid = 1'b0;
        in_op = 3'($urandom); in_src1 = {$urandom, $urandom}; in_src2 = {$urandom, $urandom};
        in_tag = TAG_W'($urandom);
    endtask

    task automatic mul_accept();
        mul_ready = 1'b1;
        @(negedge clk);
        mul_ready = 1'b0;
    endtask

    task automatic mul_return(input int lat);
        repeat (lat) @(negedge clk);
        mul_out_valid = 1'b1;
        mul_product   = mul65(mul_multiplicand, mul_multiplier);
        @(negedge clk);
        mul_out_valid = 1'b0;
        mul_product   = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || mul_valid !== 1'b0 || out_result !== 64'd0 ||
            out_tag !== '0 || mul_multiplicand !== 65'd0 || mul_multiplier !== 65'd0)
        begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b mul_valid=%b result=%h tag=%h a=%h b=%h, want 1 0 0 all-zero",
                     in_ready, out_valid, mul_valid, out_result, out_tag, mul_multiplicand, mul_multiplier);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One full op with configurable REQ stall, multiplier latency and writeback hold.
    task automatic do_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [TAG_W-1:0] tag, input int req_stall, input int lat, input int hold);
        logic [63:0] exp_res;
        logic [64:0] ea, eb;
        logic        byp;
        exp_res = ref_result(op, a, b);
        ea = ref_opa(op, a);
        eb = ref_opb(op, b);
        byp = 1'b0;
`ifdef MUL_ZERO_BYPASS_EN
        byp = (ea == 65'd0) || (eb == 65'd0);
`endif
        issue(op, a, b, tag);
        if (!byp) begin
            checks++;
            if (mul_valid !== 1'b1 || mul_multiplicand !== ea || mul_multiplier !== eb || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL request op=%0d: mul_valid=%b a=%h b=%h in_ready=%b, want 1 %h %h 0",
                         op, mul_valid, mul_multiplicand, mul_multiplier, in_ready, ea, eb);
            end
            repeat (req_stall) begin
                @(negedge clk);
                checks++;
                if (mul_valid !== 1'b1 || mul_multiplicand !== ea || mul_multiplier !== eb) begin
                    errors++;
                    $display("FAIL req_stall op=%0d: mul_valid=%b a=%h b=%h, want 1 %h %h",
                             op, mul_valid, mul_multiplicand, mul_multiplier, ea, eb);
                end
            end
            mul_accept();
            checks++;
            if (mul_valid !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL wait op=%0d: mul_valid=%b out_valid=%b, want 0 0", op, mul_valid, out_valid);
            end
            mul_return(lat);
        end
        checks++;
        if (out_valid !== 1'b1 || out_result !== exp_res || out_tag !== tag || mul_valid !== 1'b0) begin
            errors++;
            $display("FAIL result op=%0d a=%h b=%h: out_valid=%b result=%h tag=%0d mul_valid=%b, want 1 %h %0d 0",
                     op, a, b, out_valid, out_result, out_tag, mul_valid, exp_res, tag);
        end
        repeat (hold) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_result !== exp_res || out_tag !== tag || in_ready !== 1'b0 || mul_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold op=%0d: out_valid=%b result=%h tag=%0d in_ready=%b mul_valid=%b, want 1 %h %0d 0 0",
                         op, out_valid, out_result, out_tag, in_ready, mul_valid, exp_res, tag);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release op=%0d: out_valid=%b in_ready=%b, want 0 1", op, out_valid, in_ready);
        end
    endtask

    task automatic test_directed();
        do_op(3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd7, 1, 2, 0);
        do_op(3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 0, 0, 0);
        do_op(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd2, 0, 1, 0);
        do_op(3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd3, 2, 0, 1);
        do_op(3'd4, 64'h1234_5678_7FFF_FFFF, 64'd2, 5'd4, 0, 3, 0);
        do_op(3'd0, 64'd0, 64'd5, 5'd5, 0, 1, 0);
        do_op(3'd7, 64'h0000_0001_0000_0003, 64'hFFFF_FFFF_FFFF_FFFD, 5'd6, 0, 0, 0);
    endtask

    // Writeback stalls 10 cycles while a second op waits at the issue port.
    task automatic test_back_to_back();
        logic [63:0] exp1, exp2;
        exp1 = ref_result(3'd0, 64'd12345, 64'd678);
        exp2 = ref_result(3'd1, 64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFF3);
        issue(3'd0, 64'd12345, 64'd678, 5'd9);
        mul_accept();
        mul_return(1);
        in_valid = 1'b1; in_op = 3'd1; in_src1 = 64'h8000_0000_0000_0001;
        in_src2 = 64'h7FFF_FFFF_FFFF_FFF3; in_tag = 5'd21;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_result !== exp1 || out_tag !== 5'd9 || in_ready !== 1'b0 || mul_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_hold cycle %0d: out_valid=%b result=%h tag=%0d in_ready=%b mul_valid=%b, want 1 %h 9 0 0",
                         i, out_valid, out_result, out_tag, in_ready, mul_valid, exp1);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || mul_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_release: out_valid=%b in_ready=%b mul_valid=%b, want 0 1 0", out_valid, in_ready, mul_valid);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (mul_valid !== 1'b1 || mul_multiplicand !== ref_opa(3'd1, 64'h8000_0000_0000_0001) ||
            mul_multiplier !== ref_opb(3'd1, 64'h7FFF_FFFF_FFFF_FFF3)) begin
            errors++;
            $display("FAIL b2b_second_req: mul_valid=%b a=%h b=%h", mul_valid, mul_multiplicand, mul_multiplier);
        end
        mul_accept();
        mul_return(0);
        checks++;
        if (out_valid !== 1'b1 || out_result !== exp2 || out_tag !== 5'd21) begin
            errors++;
            $display("FAIL b2b_second_result: out_valid=%b result=%h tag=%0d, want 1 %h 21", out_valid, out_result, out_tag, exp2);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        // flush in IDLE: the presented op is ignored
        in_valid = 1'b1; in_op = 3'd0; in_src1 = 64'd3; in_src2 = 64'd5; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || mul_valid !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: in_ready=%b mul_valid=%b out_valid=%b, want 1 0 0", in_ready, mul_valid, out_valid);
        end
        // flush in REQ without mul_ready: straight back to IDLE
        issue(3'd0, 64'd3, 64'd5, 5'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || mul_valid !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_req: in_ready=%b mul_valid=%b out_valid=%b, want 1 0 0", in_ready, mul_valid, out_valid);
        end
        // flush together with the REQ handshake: DRAIN until the product pulse
        issue(3'd1, 64'd3, 64'd5, 5'd2);
        flush = 1'b1; mul_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; mul_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || mul_valid !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_req_hs: in_ready=%b mul_valid=%b out_valid=%b, want 0 0 0", in_ready, mul_valid, out_valid);
        end
        mul_return(2);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_req_hs_drain: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        // flush in WAIT: DRAIN ignores new ops and a second flush, product discarded
        issue(3'd0, 64'd7, 64'd9, 5'd3);
        mul_accept();
        flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || mul_valid !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_wait: in_ready=%b mul_valid=%b out_valid=%b, want 0 0 0", in_ready, mul_valid, out_valid);
        end
        mul_return(1);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || mul_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_wait_drain: in_ready=%b out_valid=%b mul_valid=%b, want 1 0 0", in_ready, out_valid, mul_valid);
        end
        // flush in WAIT in the same cycle as the product pulse: IDLE, no result
        issue(3'd0, 64'd7, 64'd9, 5'd4);
        mul_accept();
        flush = 1'b1;
        mul_return(0);
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_wait_pulse: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        // flush in DONE with out_ready also high
        issue(3'd0, 64'd7, 64'd9, 5'd5);
        mul_accept();
        mul_return(0);
        flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_done: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    // Reset hits an op waiting on the multiplier, with a product pulse and flush present.
    task automatic test_reset_wait();
        do_op(3'd0, 64'd1000, 64'd3, 5'd17, 0, 0, 0);
        issue(3'd0, 64'd11, 64'd13, 5'd19);
        mul_accept();
        rst = 1'b1; mul_out_valid = 1'b1; flush = 1'b1;
        mul_product = mul65(mul_multiplicand, mul_multiplier);
        @(negedge clk);
        mul_out_valid = 1'b0; flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || mul_valid !== 1'b0 || out_result !== 64'd0 ||
            out_tag !== '0 || mul_multiplicand !== 65'd0 || mul_multiplier !== 65'd0) begin
            errors++;
            $display("FAIL reset_wait: in_ready=%b out_valid=%b mul_valid=%b result=%h tag=%h a=%h b=%h, want 1 0 0 all-zero",
                     in_ready, out_valid, mul_valid, out_result, out_tag, mul_multiplicand, mul_multiplier);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            do_op(3'($urandom_range(0, 7)), rand_operand(), rand_operand(), TAG_W'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 2));
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_src1 = '0; in_src2 = '0;
        in_tag = '0; out_ready = 1'b0; mul_ready = 1'b0; mul_out_valid = 1'b0; mul_product = '0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_reset_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
